// File: rtl/pipeline_ctrl_if.sv
// Hazard-input / stage-control bundle between the brisc pipeline datapath and pipeline_ctrl.
// The datapath side uses the master modport, the controller uses the slave modport.
interface pipeline_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       d_rs1;
    logic [4:0]       d_rs2;
    logic             d_use_rs1;
    logic             d_use_rs2;
    logic [4:0]       e_rd;
    logic             e_is_load;
    logic             e_is_mul;
    logic             e_branch_taken;
    logic             icache_miss;
    logic             dcache_miss;

    logic             pc_en;
    logic             en_fd;
    logic             en_de;
    logic             en_em;
    logic             en_mw;
    logic             flush_fd;
    logic             flush_de;
    logic             flush_em;
    logic             flush_mw;
    logic             mul_busy;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output d_rs1, d_rs2, d_use_rs1, d_use_rs2, e_rd, e_is_load, e_is_mul,
               e_branch_taken, icache_miss, dcache_miss,
        input  pc_en, en_fd, en_de, en_em, en_mw, flush_fd, flush_de, flush_em,
               flush_mw, mul_busy, stall_cycles, flush_count
    );

    modport slave (
        input  d_rs1, d_rs2, d_use_rs1, d_use_rs2, e_rd, e_is_load, e_is_mul,
               e_branch_taken, icache_miss, dcache_miss,
        output pc_en, en_fd, en_de, en_em, en_mw, flush_fd, flush_de, flush_em,
               flush_mw, mul_busy, stall_cycles, flush_count
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Hazard/stall controller for the brisc 5-stage pipeline: fixed-priority enable/flush generation
// with a RUN/MUL multiply-occupancy FSM. Define PIPELINE_CTRL_PERF_EN to build the perf counters.
module pipeline_ctrl #(
    parameter int MUL_LAT = 3,
    parameter int CNT_W   = 32
) (
    input logic           clk,
    input logic           reset_n,
    pipeline_ctrl_if.slave bus
);
    localparam int CW = $clog2(MUL_LAT + 1);

    typedef enum logic {
        RUN = 1'b0,
        MUL = 1'b1
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    logic load_use;
    logic mul_stall;
    logic any_flush;

    logic pc_en;
    logic en_fd;
    logic en_de;
    logic en_em;
    logic en_mw;
    logic flush_fd;
    logic flush_de;
    logic flush_em;
    logic flush_mw;

    // Loads into x0 never create a dependency.
    always_comb begin
        load_use = bus.e_is_load && (bus.e_rd != 5'd0) &&
                   ((bus.d_use_rs1 && (bus.d_rs1 == bus.e_rd)) ||
                    (bus.d_use_rs2 && (bus.d_rs2 == bus.e_rd)));
        mul_stall = ((state_q == RUN) && bus.e_is_mul && (MUL_LAT > 1)) ||
                    ((state_q == MUL) && (cnt_q > CW'(1)));
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A data-cache miss outranks the multiply, so it freezes the countdown.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!bus.dcache_miss) begin
            if (mul_stall) begin
                if (state_q == RUN) begin
                    state_d = MUL;
                    cnt_d   = CW'(MUL_LAT - 1);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end else if (state_q == MUL) begin
                state_d = RUN;
                cnt_d   = '0;
            end
        end
    end

    always_comb begin
        pc_en    = 1'b1;
        en_fd    = 1'b1;
        en_de    = 1'b1;
        en_em    = 1'b1;
        en_mw    = 1'b1;
        flush_fd = 1'b0;
        flush_de = 1'b0;
        flush_em = 1'b0;
        flush_mw = 1'b0;
        if (!reset_n) begin
            pc_en    = 1'b0;
            en_fd    = 1'b0;
            en_de    = 1'b0;
            en_em    = 1'b0;
            en_mw    = 1'b0;
            flush_fd = 1'b1;
            flush_de = 1'b1;
            flush_em = 1'b1;
            flush_mw = 1'b1;
        end else if (bus.dcache_miss) begin
            pc_en    = 1'b0;
            en_fd    = 1'b0;
            en_de    = 1'b0;
            en_em    = 1'b0;
            flush_mw = 1'b1;
        end else if (mul_stall) begin
            pc_en    = 1'b0;
            en_fd    = 1'b0;
            en_de    = 1'b0;
            flush_em = 1'b1;
        end else if (bus.e_branch_taken) begin
            // PC keeps loading so the redirect also squashes any pending fetch.
            flush_fd = 1'b1;
            flush_de = 1'b1;
        end else if (load_use) begin
            pc_en    = 1'b0;
            en_fd    = 1'b0;
            flush_de = 1'b1;
        end else if (bus.icache_miss) begin
            pc_en    = 1'b0;
            flush_fd = 1'b1;
        end
    end

    assign any_flush = flush_fd | flush_de | flush_em | flush_mw;

    assign bus.pc_en    = pc_en;
    assign bus.en_fd    = en_fd;
    assign bus.en_de    = en_de;
    assign bus.en_em    = en_em;
    assign bus.en_mw    = en_mw;
    assign bus.flush_fd = flush_fd;
    assign bus.flush_de = flush_de;
    assign bus.flush_em = flush_em;
    assign bus.flush_mw = flush_mw;
    assign bus.mul_busy = reset_n && (state_q == MUL);

`ifdef PIPELINE_CTRL_PERF_EN
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flushc_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stall_q  <= '0;
            flushc_q <= '0;
        end else begin
            if (!pc_en) begin
                stall_q <= stall_q + CNT_W'(1);
            end
            if (any_flush) begin
                flushc_q <= flushc_q + CNT_W'(1);
            end
        end
    end

    assign bus.stall_cycles = reset_n ? stall_q : '0;
    assign bus.flush_count  = reset_n ? flushc_q : '0;
`else
    logic unused_perf;
    assign unused_perf      = any_flush;
    assign bus.stall_cycles = '0;
    assign bus.flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl (MUL_LAT=4): per-cycle comparison against a behavioural
// model, plus directed scenarios with hand-computed expectations.
module tb_pipeline_ctrl;
    localparam int MUL_LAT = 4;
    localparam int CNT_W   = 32;

    logic clk = 1'b0;
    logic reset_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    pipeline_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipeline_ctrl #(.MUL_LAT(MUL_LAT), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // {pc_en, en_fd, en_de, en_em, en_mw, flush_fd, flush_de, flush_em, flush_mw}
    localparam logic [8:0] C_RESET  = 9'b0_0000_1111;
    localparam logic [8:0] C_NORMAL = 9'b1_1111_0000;
    localparam logic [8:0] C_DMISS  = 9'b0_0001_0001;
    localparam logic [8:0] C_MULST  = 9'b0_0011_0010;
    localparam logic [8:0] C_BRANCH = 9'b1_1111_1100;
    localparam logic [8:0] C_LDUSE  = 9'b0_0111_0100;
    localparam logic [8:0] C_IMISS  = 9'b0_1111_1000;

    function automatic logic [8:0] ctl();
        return {bus.pc_en, bus.en_fd, bus.en_de, bus.en_em, bus.en_mw,
                bus.flush_fd, bus.flush_de, bus.flush_em, bus.flush_mw};
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: a multiply in E needs MUL_LAT-1 stall cycles; count them up while "in multiply".
    bit          m_in_mul = 1'b0;
    int unsigned m_served = 0;
    logic [CNT_W-1:0] m_stall = '0;
    logic [CNT_W-1:0] m_flush = '0;

    always @(negedge clk) begin
        logic [8:0] e;
        logic       busy_e;
        logic       mul_hz;
        logic       lu;
        logic       hit1;
        logic       hit2;
        logic [CNT_W-1:0] es;
        logic [CNT_W-1:0] ef;
        if (!reset_n) begin
            e      = C_RESET;
            busy_e = 1'b0;
            mul_hz = 1'b0;
        end else begin
            busy_e = m_in_mul;
            mul_hz = m_in_mul ? (m_served < MUL_LAT - 1) : (bus.e_is_mul && MUL_LAT > 1);
            hit1   = bus.d_use_rs1 && bus.d_rs1 == bus.e_rd;
            hit2   = bus.d_use_rs2 && bus.d_rs2 == bus.e_rd;
            lu     = bus.e_is_load && bus.e_rd != 0 && (hit1 || hit2);
            if (bus.dcache_miss)         e = C_DMISS;
            else if (mul_hz)             e = C_MULST;
            else if (bus.e_branch_taken) e = C_BRANCH;
            else if (lu)                 e = C_LDUSE;
            else if (bus.icache_miss)    e = C_IMISS;
            else                         e = C_NORMAL;
        end
`ifdef PIPELINE_CTRL_PERF_EN
        es = reset_n ? m_stall : '0;
        ef = reset_n ? m_flush : '0;
`else
        es = '0;
        ef = '0;
`endif
        check("model_ctl", 64'(ctl()), 64'(e));
        check("model_mul_busy", 64'(bus.mul_busy), 64'(busy_e));
        check("model_stall_cycles", 64'(bus.stall_cycles), 64'(es));
        check("model_flush_count", 64'(bus.flush_count), 64'(ef));
        if (!reset_n) begin
            m_in_mul = 1'b0;
            m_served = 0;
            m_stall  = '0;
            m_flush  = '0;
        end else begin
            if (!bus.dcache_miss) begin
                if (m_in_mul) begin
                    if (m_served < MUL_LAT - 1) m_served++;
                    else m_in_mul = 1'b0;
                end else if (bus.e_is_mul && MUL_LAT > 1) begin
                    m_in_mul = 1'b1;
                    m_served = 1;
                end
            end
            if (!e[8])   m_stall = m_stall + 1'b1;
            if (|e[3:0]) m_flush = m_flush + 1'b1;
        end
    end

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic clear();
        bus.d_rs1          = '0;
        bus.d_rs2          = '0;
        bus.d_use_rs1      = 1'b0;
        bus.d_use_rs2      = 1'b0;
        bus.e_rd           = '0;
        bus.e_is_load      = 1'b0;
        bus.e_is_mul       = 1'b0;
        bus.e_branch_taken = 1'b0;
        bus.icache_miss    = 1'b0;
        bus.dcache_miss    = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time bound");
        $fatal(1);
    end

    initial begin
        int frz;
        int bsy;
        int mw;
        logic [CNT_W-1:0] exp_cnt;
        clear();
        reset_n = 1'b0;

        // Reset held two cycles, then released with no hazards.
        smp();
        check("reset_ctl_1", 64'(ctl()), 64'(C_RESET));
        check("reset_busy", 64'(bus.mul_busy), 64'd0);
        adv();
        smp();
        check("reset_ctl_2", 64'(ctl()), 64'(C_RESET));
        check("reset_stall_cnt", 64'(bus.stall_cycles), 64'd0);
        adv();
        reset_n = 1'b1;
        smp();
        check("release_ctl", 64'(ctl()), 64'(C_NORMAL));

        // Load-use on rs2, then the same with a load to x0, then a 2-cycle icache miss.
        adv();
        bus.e_is_load = 1'b1; bus.e_rd = 5'd5; bus.d_rs2 = 5'd5; bus.d_use_rs2 = 1'b1;
        smp();
        check("ldu_pc_en", 64'(bus.pc_en), 64'd0);
        check("ldu_en_fd", 64'(bus.en_fd), 64'd0);
        check("ldu_flush_de", 64'(bus.flush_de), 64'd1);
        adv();
        bus.e_rd = 5'd0; bus.d_rs2 = 5'd0;
        smp();
        check("ldu_x0_ctl", 64'(ctl()), 64'(C_NORMAL));
        adv();
        clear();
        bus.icache_miss = 1'b1;
        smp();
        check("imiss_ctl", 64'(ctl()), 64'(C_IMISS));
        adv();
        smp();
        adv();
        clear();
        smp();
`ifdef PIPELINE_CTRL_PERF_EN
        exp_cnt = CNT_W'(3);
`else
        exp_cnt = '0;
`endif
        check("perf_stall_cycles", 64'(bus.stall_cycles), 64'(exp_cnt));
        check("perf_flush_count", 64'(bus.flush_count), 64'(exp_cnt));

        // Load-use via rs1; a matching rs1 that is not read must not stall.
        adv();
        bus.e_is_load = 1'b1; bus.e_rd = 5'd17; bus.d_rs1 = 5'd17; bus.d_use_rs1 = 1'b1;
        smp();
        check("ldu_rs1_ctl", 64'(ctl()), 64'(C_LDUSE));
        adv();
        bus.d_use_rs1 = 1'b0;
        smp();
        check("ldu_unused_ctl", 64'(ctl()), 64'(C_NORMAL));

        // Single multiply pulse: 3 stall cycles, 3 busy cycles.
        adv();
        clear();
        frz = 0; bsy = 0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) adv();
            bus.e_is_mul = (i == 0);
            smp();
            if (!bus.en_de && bus.flush_em) frz++;
            if (bus.mul_busy) bsy++;
        end
        check("mul_freeze_cycles", 64'(frz), 64'd3);
        check("mul_busy_cycles", 64'(bsy), 64'd3);

        // Multiply with a 2-cycle dcache miss in its second stall cycle.
        adv();
        frz = 0; mw = 0;
        for (int i = 0; i < 9; i++) begin
            if (i > 0) adv();
            bus.e_is_mul    = (i == 0);
            bus.dcache_miss = (i == 1 || i == 2);
            smp();
            if (!bus.en_de) frz++;
            if (bus.flush_mw) mw++;
            check("miss_mul_flush_mw", 64'(bus.flush_mw), 64'(i == 1 || i == 2));
        end
        check("miss_mul_freeze", 64'(frz), 64'd5);
        check("miss_mul_mw_cycles", 64'(mw), 64'd2);

        // Back-to-back multiplies: the second arrives on the release cycle + 1.
        adv();
        frz = 0; bsy = 0;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) adv();
            bus.e_is_mul = (i == 0 || i == 4);
            smp();
            if (!bus.en_de) frz++;
            if (bus.mul_busy) bsy++;
            if (i == 4) begin
                check("b2b_reenter_busy", 64'(bus.mul_busy), 64'd0);
                check("b2b_reenter_ctl", 64'(ctl()), 64'(C_MULST));
            end
        end
        check("b2b_freeze", 64'(frz), 64'd6);
        check("b2b_busy", 64'(bsy), 64'd6);

        // Branch priority over icache miss and load-use; dcache miss beats branch.
        adv();
        clear();
        bus.e_branch_taken = 1'b1; bus.icache_miss = 1'b1;
        smp();
        check("br_imiss_ctl", 64'(ctl()), 64'(C_BRANCH));
        adv();
        bus.icache_miss = 1'b0; bus.dcache_miss = 1'b1;
        smp();
        check("br_dmiss_ctl", 64'(ctl()), 64'(C_DMISS));
        check("br_dmiss_flush_fd", 64'(bus.flush_fd), 64'd0);
        adv();
        bus.dcache_miss = 1'b0;
        bus.e_is_load = 1'b1; bus.e_rd = 5'd9; bus.d_rs1 = 5'd9; bus.d_use_rs1 = 1'b1;
        smp();
        check("br_ldu_ctl", 64'(ctl()), 64'(C_BRANCH));

        // Reset asserted while in MUL abandons the multiply.
        adv();
        clear();
        bus.e_is_mul = 1'b1;
        smp();
        adv();
        bus.e_is_mul = 1'b0;
        smp();
        check("rst_mul_busy_before", 64'(bus.mul_busy), 64'd1);
        adv();
        reset_n = 1'b0;
        smp();
        check("rst_mul_ctl", 64'(ctl()), 64'(C_RESET));
        check("rst_mul_busy", 64'(bus.mul_busy), 64'd0);
        adv();
        reset_n = 1'b1;
        smp();
        check("rst_mul_after_ctl", 64'(ctl()), 64'(C_NORMAL));
        check("rst_mul_after_busy", 64'(bus.mul_busy), 64'd0);

        adv();
        smp();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Hazard and stall controller for the brisc 5-stage pipeline (F/D/E/M/W). Generates the `enable` and `flush` signals for the four inter-stage `ff` register banks and the PC register, so that the pipeline registers themselves stay passive. It resolves five hazard sources by fixed priority:

- data-cache miss
- multicycle multiply
- taken branch
- load-use dependency
- instruction-cache miss

It tracks multiply occupancy with a countdown FSM.

## Interface
Parameters:
- `MUL_LAT`, 3: cycles a multiply occupies E (≥1); stall length is `MUL_LAT-1`.
- `CNT_W`, 32: width of the performance counters.

Ports:
- `clk` in 1: clock; all state updates on posedge.
- `reset_n` in 1: reset, **synchronous, active-low**.
- `d_rs1`, `d_rs2` in 5: source registers of the instruction in D.
- `d_use_rs1`, `d_use_rs2` in 1: D instruction actually reads rs1/rs2.
- `e_rd` in 5: destination register of the instruction in E.
- `e_is_load` in 1: E holds a load.
- `e_is_mul` in 1: E holds a multiply.
- `e_branch_taken` in 1: E resolved a taken branch or jump.
- `icache_miss` in 1: F fetch miss, held high until the fill completes.
- `dcache_miss` in 1: M access miss, held high until the fill completes.
- `pc_en` out 1: PC register enable.
- `en_fd`, `en_de`, `en_em`, `en_mw` out 1 each: pipeline-register enables.
- `flush_fd`, `flush_de`, `flush_em`, `flush_mw` out 1 each: active-high synchronous clear to the register's reset value (a bubble). Flush overrides enable.
- `mul_busy` out 1: controller is in the `MUL` state.
- `stall_cycles`, `flush_count` out `CNT_W` each: performance counters (see Configuration).

## Operation
- FSM states: `RUN`, `MUL`. A down-counter `cnt` of width `$clog2(MUL_LAT+1)` tracks multiply occupancy.
- Default in `RUN` with no hazard: `pc_en` and all `en_*` = 1; all `flush_*` = 0.
- Priority, highest first. Only the highest active rule drives the outputs.
  1. **`dcache_miss`**: `pc_en`, `en_fd`, `en_de`, `en_em` = 0; `flush_mw` = 1. The FSM state and `cnt` hold.
  2. **Multiply stall**: condition is (`RUN` and `e_is_mul` and `MUL_LAT>1`), or (`MUL` and `cnt>1`). Outputs: `pc_en`, `en_fd`, `en_de` = 0; `flush_em` = 1. Transitions:
     - From `RUN`: go to `MUL` with `cnt=MUL_LAT-1`.
     - In `MUL`: `cnt` decrements.
     - `MUL` with `cnt==1`: no stall (default outputs), go to `RUN`, `cnt` goes to 0.
  3. **`e_branch_taken`**: `pc_en` = 1 (redirect); `flush_fd` = `flush_de` = 1.
  4. **Load-use**: condition is `e_is_load` and `e_rd!=0` and ((`d_use_rs1` and `d_rs1==e_rd`) or (`d_use_rs2` and `d_rs2==e_rd`)). Outputs: `pc_en` = `en_fd` = 0; `flush_de` = 1.
  5. **`icache_miss`**: `pc_en` = 0; `flush_fd` = 1; later stages advance normally.
- A lower-priority hazard masked in a cycle is re-evaluated the next cycle; nothing is queued.
- A load to `x0` never causes a load-use stall.

## Timing
- All outputs are combinational from the current inputs and the registered state; there is zero-cycle latency from hazard input to enable/flush.
- State and counters update on posedge `clk`.
- While `reset_n` is low: `pc_en` and all `en_*` = 0, all `flush_*` = 1, `mul_busy` = 0, counters are 0.
  - The next state is `RUN` with `cnt=0`.
  - The first cycle after release uses normal rules.
- `reset_n` asserted during `MUL`: the multiply is abandoned and the FSM enters `RUN`.
- Multiply with `MUL_LAT=1`: no stall and the FSM never enters `MUL`.
- Multiply with `MUL_LAT=3`: E is frozen for 2 cycles and advances on the 3rd.
- `dcache_miss` during `MUL` freezes `cnt`. The remaining multiply stall resumes after the miss clears.
- `e_branch_taken` with `icache_miss`: the branch wins. `pc_en` = 1 squashes the pending fetch.
- Back-to-back multiplies: the cycle after `MUL`→`RUN` sees the new `e_is_mul` and re-enters `MUL`.

## Configuration
- `PIPELINE_CTRL_PERF_EN` defined:
  - `stall_cycles` increments each cycle that `pc_en==0` while `reset_n` is high.
  - `flush_count` increments each cycle that any of `flush_fd`, `flush_de`, `flush_em`, `flush_mw` is 1 while `reset_n` is high.
  - Both counters wrap modulo 2^`CNT_W`.
- `PIPELINE_CTRL_PERF_EN` undefined: both outputs are tied to 0 and no counter flops are inferred.

## Test plan
- **Reset**: hold `reset_n`=0 for 2 cycles → all `flush_*`=1, `pc_en`=0. Release with no hazards → next cycle all `en_*`=1, `flush_*`=0.
- **Load-use**: `e_is_load`=1, `e_rd`=5, `d_rs2`=5, `d_use_rs2`=1 → `pc_en`=0, `en_fd`=0, `flush_de`=1. Repeat with `e_rd`=0 → no stall.
- **Multiply**: `MUL_LAT`=4, `e_is_mul` pulse → exactly 3 cycles of `en_de`=0 with `flush_em`=1, `mul_busy`=1 for 3 cycles, then normal.
- **Miss during multiply**: same as the multiply case, plus `dcache_miss` for 2 cycles in the 2nd stall cycle → total E freeze of 5 cycles. `flush_mw`=1 only during the miss.
- **Branch priority**: `e_branch_taken`=1 with `icache_miss`=1 → `pc_en`=1, `flush_fd`=`flush_de`=1. Then `e_branch_taken`=1 with `dcache_miss`=1 → the miss wins, `flush_fd`=0.
- **Performance counters** (`PIPELINE_CTRL_PERF_EN` defined): one load-use stall + 2-cycle icache miss → `stall_cycles`=3, `flush_count`=3. With the macro undefined, both outputs read 0.
